// File: rtl/multi_clk_en_gen_if.sv
// Control/status bundle for multi_clk_en_gen: run enables, divisor write port, sync and enable outputs.
// sq_out exists only when MULTI_CLK_EN_SQUARE_EN is defined.
interface multi_clk_en_gen_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    run;
  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [DIV_WIDTH-1:0] wr_div;
  logic                 sync;
  logic [NUM_CH-1:0]    clk_en;
  logic [NUM_CH-1:0]    pending;
`ifdef MULTI_CLK_EN_SQUARE_EN
  logic [NUM_CH-1:0]    sq_out;

  modport master (output run, wr_en, wr_ch, wr_div, sync,
                  input  clk_en, pending, sq_out);
  modport slave  (input  run, wr_en, wr_ch, wr_div, sync,
                  output clk_en, pending, sq_out);
`else
  modport master (output run, wr_en, wr_ch, wr_div, sync,
                  input  clk_en, pending);
  modport slave  (input  run, wr_en, wr_ch, wr_div, sync,
                  output clk_en, pending);
`endif
endinterface

// File: rtl/multi_clk_en_gen.sv
// NUM_CH independent clock-enable dividers with glitch-free shadowed divisor updates and global sync.
// Optional square-wave outputs (sq_out) are built when MULTI_CLK_EN_SQUARE_EN is defined.
module multi_clk_en_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 40
) (
  input logic             CLK_40,
  input logic             reset,
  multi_clk_en_gen_if.slave bus
);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
  logic [DIV_WIDTH-1:0] cnt_d [NUM_CH];
  logic [DIV_WIDTH-1:0] act_q [NUM_CH];
  logic [DIV_WIDTH-1:0] act_d [NUM_CH];
  logic [DIV_WIDTH-1:0] sh_q  [NUM_CH];
  logic [DIV_WIDTH-1:0] sh_d  [NUM_CH];
  logic [DIV_WIDTH-1:0] term  [NUM_CH];
  logic [NUM_CH-1:0]    pend_q, pend_d;
  logic [NUM_CH-1:0]    en_q, en_d;
  logic [NUM_CH-1:0]    wr_hit, act_zero, tc;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_hit[g]   = bus.wr_en && (32'(bus.wr_ch) == g);
    assign act_zero[g] = (act_q[g] == '0);
    // terminal value is only formed for a non-zero divisor
    assign term[g]     = act_zero[g] ? '0 : act_q[g] - ONE;
    assign tc[g]       = bus.run[g] && !act_zero[g] && (cnt_q[g] == term[g]);
  end

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    en_d   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_hit[i]) sh_d[i] = bus.wr_div;
      if (bus.sync) begin
        cnt_d[i]  = '0;
        pend_d[i] = 1'b0;
        if (wr_hit[i])      act_d[i] = bus.wr_div;
        else if (pend_q[i]) act_d[i] = sh_q[i];
      end else if (tc[i]) begin
        cnt_d[i]  = '0;
        en_d[i]   = 1'b1;
        pend_d[i] = 1'b0;
        if (wr_hit[i])      act_d[i] = bus.wr_div;
        else if (pend_q[i]) act_d[i] = sh_q[i];
      end else begin
        if (act_zero[i])      cnt_d[i] = '0;
        else if (bus.run[i])  cnt_d[i] = cnt_q[i] + ONE;
        // idle or disabled channels take a pending divisor without waiting
        if (pend_q[i] && (act_zero[i] || !bus.run[i])) begin
          act_d[i]  = sh_q[i];
          pend_d[i] = 1'b0;
        end
        if (wr_hit[i]) pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      cnt_q  <= '{default: '0};
      act_q  <= '{default: DEF};
      sh_q   <= '{default: DEF};
      pend_q <= '0;
      en_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      en_q   <= en_d;
    end
  end

  assign bus.clk_en  = en_q;
  assign bus.pending = pend_q;

`ifdef MULTI_CLK_EN_SQUARE_EN
  logic [NUM_CH-1:0] sq_q, sq_d;

  always_comb begin
    sq_d = bus.sync ? '0 : (sq_q ^ en_d);
  end

  always_ff @(posedge CLK_40) begin
    if (reset) sq_q <= '0;
    else       sq_q <= sq_d;
  end

  assign bus.sq_out = sq_q;
`endif
endmodule

// File: tb/tb_multi_clk_en_gen.sv
// Bench for multi_clk_en_gen: per-cycle comparison against an integer period model plus directed timing checks.
module tb_multi_clk_en_gen;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int DEF = 40;

  logic CLK_40 = 1'b0;
  logic reset  = 1'b1;
  always #5 CLK_40 = ~CLK_40;

  multi_clk_en_gen_if #(.NUM_CH(NCH), .DIV_WIDTH(DW)) bus ();
  multi_clk_en_gen #(.NUM_CH(NCH), .DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
    .CLK_40 (CLK_40),
    .reset  (reset),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mvalid = 0;

  // model: each channel tracks its position in the current period in plain integers
  int m_cnt [NCH];
  int m_act [NCH];
  int m_sh  [NCH];
  bit m_pend[NCH];
  bit m_en  [NCH];
  bit m_sq  [NCH];

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit w, at_end;
      if (reset) begin
        m_cnt[i] = 0; m_act[i] = DEF; m_sh[i] = DEF;
        m_pend[i] = 0; m_en[i] = 0; m_sq[i] = 0;
        continue;
      end
      w      = bus.wr_en && (int'(bus.wr_ch) == i);
      at_end = bus.run[i] && (m_act[i] != 0) && (m_cnt[i] == m_act[i] - 1);
      if (bus.sync) begin
        if (w)              m_act[i] = int'(bus.wr_div);
        else if (m_pend[i]) m_act[i] = m_sh[i];
        if (w) m_sh[i] = int'(bus.wr_div);
        m_pend[i] = 0; m_cnt[i] = 0; m_en[i] = 0; m_sq[i] = 0;
      end else if (at_end) begin
        m_en[i] = 1; m_sq[i] = !m_sq[i]; m_cnt[i] = 0;
        if (w) begin
          m_act[i] = int'(bus.wr_div); m_sh[i] = int'(bus.wr_div);
        end else if (m_pend[i]) begin
          m_act[i] = m_sh[i];
        end
        m_pend[i] = 0;
      end else begin
        m_en[i] = 0;
        if (m_act[i] == 0)    m_cnt[i] = 0;
        else if (bus.run[i])  m_cnt[i] = m_cnt[i] + 1;
        if (m_pend[i] && (m_act[i] == 0 || !bus.run[i])) begin
          m_act[i] = m_sh[i]; m_pend[i] = 0;
        end
        if (w) begin m_sh[i] = int'(bus.wr_div); m_pend[i] = 1; end
      end
    end
    if (reset) mvalid = 1;
  endtask

  always @(posedge CLK_40) begin
    cyc++;
    model_step();
  end

  always @(negedge CLK_40) begin
    if (mvalid) begin
      logic [NCH-1:0] e_en, e_pend, e_sq, a_sq;
      for (int i = 0; i < NCH; i++) begin
        e_en[i] = m_en[i]; e_pend[i] = m_pend[i]; e_sq[i] = m_sq[i];
      end
`ifdef MULTI_CLK_EN_SQUARE_EN
      a_sq = bus.sq_out;
`else
      a_sq = e_sq;
`endif
      n_cmp++;
      if (bus.clk_en !== e_en || bus.pending !== e_pend || a_sq !== e_sq) begin
        n_fail++;
        $display("FAIL model cyc=%0d: clk_en=%b pending=%b sq=%b, required clk_en=%b pending=%b sq=%b",
                 cyc, bus.clk_en, bus.pending, a_sq, e_en, e_pend, e_sq);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_pulse(input int ch, output int t);
    t = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK_40);
      if (bus.clk_en[ch]) begin t = cyc; return; end
    end
    n_cmp++; n_fail++;
    $display("FAIL timeout waiting for clk_en[%0d]: got none in 100 cycles, required a pulse", ch);
  endtask

  task automatic wr(input int ch, input int val);
    bus.wr_en = 1'b1; bus.wr_ch = 2'(ch); bus.wr_div = 16'(val);
    @(negedge CLK_40);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_sync();
    bus.sync = 1'b1;
    @(negedge CLK_40);
    bus.sync = 1'b0;
  endtask

  initial begin
    int t0, t, ep, tw, ts, tr, p, c2, c3, c0;
    bus.run = 4'hF; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_div = '0; bus.sync = 1'b0;
    repeat (3) @(negedge CLK_40);
    check("reset clk_en", int'(bus.clk_en), 0);
    check("reset pending", int'(bus.pending), 0);
    reset = 1'b0; t0 = cyc;

    // default divisor, all channels in phase
    wait_pulse(0, t);  check("first pulse time", t - t0, 40);
    check("in phase 1", int'(bus.clk_en), 15);
    wait_pulse(0, ep); check("second pulse time", ep - t0, 80);
    check("in phase 2", int'(bus.clk_en), 15);

    // shadowed update of channel 1 at cnt=10
    repeat (10) @(negedge CLK_40);
    wr(1, 5);
    check("pending[1] after write", int'(bus.pending[1]), 1);
    wait_pulse(1, t);  check("old period completes", t - ep, 40);
    check("pending[1] cleared", int'(bus.pending[1]), 0);
    wait_pulse(1, t);  check("div5 pulse 1", t - ep, 45);
    wait_pulse(1, t);  check("div5 pulse 2", t - ep, 50);

    // divisor 1 and divisor 0
    wr(2, 1); wr(3, 0);
    repeat (40) @(negedge CLK_40);
    c2 = 0; c3 = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK_40);
      c2 += int'(bus.clk_en[2]); c3 += int'(bus.clk_en[3]);
    end
    check("div1 continuous", c2, 16);
    check("div0 silent", c3, 0);
    wr(3, 8); tw = cyc;
    wait_pulse(3, t);  check("div0->8 first pulse", t - tw, 9);
    wait_pulse(3, t);  check("div8 second pulse", t - tw, 17);

    // sync on channel 0 terminal count
    wr(0, 3); wr(1, 7); wr(2, 40);
    do_sync();
    wait_pulse(0, p);
    repeat (2) @(negedge CLK_40);
    do_sync(); ts = cyc;
    check("sync suppresses tc", p + 3, ts);
    check("no pulse after sync", int'(bus.clk_en), 0);
    wait_pulse(0, t);  check("sync ch0 +3", t - ts, 3);
    wait_pulse(1, t);  check("sync ch1 +7", t - ts, 7);
    wait_pulse(2, t);  check("sync ch2 +40", t - ts, 40);

    // run gating mid-period
    wr(0, 40);
    do_sync(); ts = cyc;
    repeat (20) @(negedge CLK_40);
    bus.run[0] = 1'b0; c0 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK_40);
      c0 += int'(bus.clk_en[0]);
    end
    check("run low no pulse", c0, 0);
    bus.run[0] = 1'b1; tr = cyc + 1;
    wait_pulse(0, t);  check("resume held count", t - tr, 19);

    // reset mid-period discards counts and pending writes
    repeat (7) @(negedge CLK_40);
    wr(1, 9);
    check("pending before reset", int'(bus.pending[1]), 1);
    reset = 1'b1;
    @(negedge CLK_40);
    check("mid reset clk_en", int'(bus.clk_en), 0);
    check("mid reset pending", int'(bus.pending), 0);
    reset = 1'b0; t0 = cyc;
    wait_pulse(0, t);  check("pulse after re-reset", t - t0, 40);

`ifdef MULTI_CLK_EN_SQUARE_EN
    wr(1, 5);
    do_sync(); ts = cyc;
    check("sq cleared by sync", int'(bus.sq_out), 0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK_40);
      check($sformatf("sq_out[1] at +%0d", k), int'(bus.sq_out[1]), (k / 5) % 2);
    end
`endif

    repeat (3) @(negedge CLK_40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_clk_en_gen.md
MULTI_CLK_EN_GEN -- requirements
Module: multi_clk_en_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent clock-enable channels, legal range 1..16.
REQ-002 The block SHALL have parameter DIV_WIDTH, default 16: width of each channel's divisor and counter.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 40: divisor loaded into every channel at reset, 1 <= DEFAULT_DIV < 2^DIV_WIDTH.
REQ-004 The block SHALL have port CLK_40, input, 1 bit: system clock; all logic sits on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port run, input, NUM_CH bits: per-channel run enable.
REQ-007 The block SHALL have port wr_en, input, 1 bit: divisor write strobe.
REQ-008 The block SHALL have port wr_ch, input, max(1,$clog2(NUM_CH)) bits: channel index for the write.
REQ-009 The block SHALL have port wr_div, input, DIV_WIDTH bits: new divisor value.
REQ-010 The block SHALL have port sync, input, 1 bit: phase-align pulse that restarts all channels.
REQ-011 The block SHALL have port clk_en, output, NUM_CH bits: one-cycle enable pulse per channel.
REQ-012 The block SHALL have port pending, output, NUM_CH bits: channel has a written divisor not yet applied.

Function
REQ-013 Each channel SHALL hold an active divisor div_act, a shadow divisor div_sh and a counter cnt. The counter counts 0..div_act-1 while run is high, then wraps to 0.
REQ-014 clk_en[i] SHALL be registered: it is high in cycle n+1 only if, in cycle n, run[i]=1, div_act>=1 and cnt==div_act-1. This gives exactly one pulse per div_act running cycles.
REQ-015 With div_act==1, clk_en[i] SHALL stay high every cycle while run[i]=1.
REQ-016 With div_act==0, the channel SHALL be disabled: cnt is held at 0 and clk_en[i] stays 0 regardless of run[i].
REQ-017 While run[i]=0, cnt SHALL hold its value and clk_en[i] SHALL be 0 one cycle later. When run[i] returns to 1, counting SHALL resume from the held count.
REQ-018 A write (wr_en=1, wr_ch<NUM_CH) SHALL load wr_div into div_sh[wr_ch] and set pending[wr_ch] on the next cycle. A write with wr_ch>=NUM_CH SHALL be ignored.
REQ-019 A pending shadow SHALL be copied to div_act at the channel's terminal count (cnt==div_act-1 with run=1), and cnt SHALL wrap to 0 at the same time. The period in progress always completes at the old divisor, so no shortened or glitched period is ever produced.
REQ-020 If run[i]=0 or div_act==0, a pending shadow SHALL be applied on the next cycle without waiting for a terminal count.
REQ-021 If a write to channel i coincides with its terminal count, the written value SHALL become div_act directly for the next period, and pending[i] SHALL remain 0.
REQ-022 A second write before application SHALL overwrite div_sh. Only the last value is applied.
REQ-023 When sync=1, the next cycle SHALL have every cnt=0, every clk_en=0, and all pending shadows applied with pending cleared. sync SHALL take priority over a simultaneous terminal count, which produces no pulse. A write in the same cycle as sync SHALL be applied as well.
REQ-024 Counter and compare arithmetic SHALL be unsigned at DIV_WIDTH bits. div_act-1 SHALL NOT be evaluated when div_act==0.

Reset
REQ-025 While reset=1, on each CLK_40 edge: cnt=0, div_act=div_sh=DEFAULT_DIV, pending=0, clk_en=0 (and sq_out=0 when configured) for every channel.
REQ-026 reset SHALL override sync, wr_en and run. A reset asserted mid-period SHALL discard the partial count and any pending write.
REQ-027 After reset deasserts with run[i]=1, the first clk_en[i] pulse SHALL occur DEFAULT_DIV cycles later.

Configuration
REQ-028 When macro MULTI_CLK_EN_SQUARE_EN is defined, the block SHALL add output sq_out, NUM_CH bits. sq_out[i] is registered and toggles in the same cycle clk_en[i] rises, giving a square wave of period 2*div_act cycles. sq_out is cleared by reset and by sync.
REQ-029 When MULTI_CLK_EN_SQUARE_EN is undefined, sq_out and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-030 After reset with defaults and run=4'hF, the bench SHALL check that each clk_en pulses for 1 cycle every 40 cycles, first pulse 40 cycles after reset release, all channels in phase.
REQ-031 Channel 1 running at div 40: write wr_div=5 at cnt=10. The bench SHALL check pending[1]=1, the next pulse still arrives at the 40-count boundary, pulses then come every 5 cycles, and pending[1]=0 after application.
REQ-032 Program channel 2 to div=1 and channel 3 to div=0. The bench SHALL check clk_en[2] is continuously high and clk_en[3] is always 0. Writing 8 to channel 3 SHALL apply next cycle and pulse every 8 cycles.
REQ-033 Channels at divs 3, 7 and 40: pulse sync in a cycle where channel 0 is at terminal count. The bench SHALL check no pulse on channel 0 next cycle, then the first pulses at +3, +7 and +40 cycles after sync.
REQ-034 Drop run[0] for 12 cycles at cnt=20 (div 40). The bench SHALL check clk_en[0] stays low and the next pulse arrives 20 running cycles after resume. Assert reset mid-period and check all outputs are 0 next cycle.
REQ-035 With MULTI_CLK_EN_SQUARE_EN defined and div=5, the bench SHALL check sq_out toggles every 5 cycles (period 10). Without the macro, the same bench SHALL compile without sq_out.
